// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader frame parser.
//   state_t   : frame parser states
//   err_t     : abort reason reported on err_code
//   SYNC_BYTE : first byte of every image frame
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    CHECK,
    DONE,
    SKIP,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_boot_loader_ctrl_counter.sv
// Loadable up/down counter shared by the loader datapath.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (count -> 0)
//   load_i      : load load_val_i (has priority over en_i)
//   load_val_i  : value loaded when load_i=1
//   en_i        : step the count by one (up, or down when DOWN=1)
//   count_o     : current count
module uart_boot_loader_ctrl_counter #(
  parameter int WIDTH = 8,
  parameter bit DOWN  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: state registers use non-blocking assignments and the reset is
  // sampled inside the clocked block, so reset only acts on a clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i) begin
      count_q <= DOWN ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/uart_boot_loader_ctrl.sv
// Frame parser and RAM write sequencer between the UART byte receiver and
// the boot image RAM. Frame: SYNC_BYTE, len[7:0], len[15:8], len payload
// bytes, checksum byte (sum of length, payload and checksum bytes == 0 mod 256).
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   byte_valid, byte_data  : received byte strobe and value
//   rx_timeout             : sticky receiver idle timeout
//   mem_we/addr/wdata      : RAM byte write, one cycle after each payload byte
//   busy                   : frame in progress
//   done / skip / error    : terminal result levels, err_code gives the reason
module uart_boot_loader_ctrl
  import loader_pkg::*;
#(
  parameter  int MEM_DEPTH = 4096,
  localparam int ADDR_BITS = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  input  logic                 rx_timeout,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 skip,
  output logic                 error,
  output logic [1:0]           err_code
);

  state_t               state_q;
  err_t                 err_q;
  logic [7:0]           len_lo_q;
  logic [7:0]           sum_q;
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [7:0]           wdata_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 skip_q;
  logic                 error_q;

  logic [15:0]          len_full;
  logic                 start_payload;
  logic                 payload_byte;
  logic [ADDR_BITS-1:0] addr_cnt;
  logic [15:0]          rem_cnt;
  logic                 active;

  assign len_full      = {byte_data, len_lo_q};
  assign start_payload = byte_valid && (state_q == LEN_HI) &&
                         (len_full != 16'd0) && (len_full <= 16'(MEM_DEPTH));
  assign payload_byte  = byte_valid && (state_q == PAYLOAD);
  assign active        = state_q inside {LEN_LO, LEN_HI, PAYLOAD, CHECK};

  uart_boot_loader_ctrl_counter #(
    .WIDTH (ADDR_BITS),
    .DOWN  (1'b0)
  ) u_addr_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start_payload),
    .load_val_i ('0),
    .en_i       (payload_byte),
    .count_o    (addr_cnt)
  );

  uart_boot_loader_ctrl_counter #(
    .WIDTH (16),
    .DOWN  (1'b1)
  ) u_rem_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start_payload),
    .load_val_i (len_full),
    .en_i       (payload_byte),
    .count_o    (rem_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      err_q    <= ERR_NONE;
      len_lo_q <= '0;
      sum_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      skip_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      // NOTE: the write strobe defaults low every cycle so it pulses exactly
      // once per accepted payload byte.
      we_q <= 1'b0;
      // A byte always takes precedence; a timeout with no byte aborts the frame.
      if (active && !byte_valid && rx_timeout) begin
        state_q <= ERROR;
        err_q   <= ERR_TIMEOUT;
        error_q <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (byte_valid && byte_data == SYNC_BYTE) begin
              state_q <= LEN_LO;
              sum_q   <= '0;
              busy_q  <= 1'b1;
            end else if (rx_timeout) begin
              state_q <= SKIP;
              skip_q  <= 1'b1;
            end
          end
          LEN_LO: begin
            if (byte_valid) begin
              len_lo_q <= byte_data;
              sum_q    <= sum_q + byte_data;
              state_q  <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (byte_valid) begin
              sum_q <= sum_q + byte_data;
              if (len_full > 16'(MEM_DEPTH)) begin
                state_q <= ERROR;
                err_q   <= ERR_LEN;
                error_q <= 1'b1;
                busy_q  <= 1'b0;
              end else if (len_full == 16'd0) begin
                state_q <= CHECK;
              end else begin
                state_q <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (byte_valid) begin
              we_q    <= 1'b1;
              addr_q  <= addr_cnt;
              wdata_q <= byte_data;
              sum_q   <= sum_q + byte_data;
              // rem_cnt still holds the pre-decrement count for this byte.
              if (rem_cnt == 16'd1) begin
                state_q <= CHECK;
              end
            end
          end
          CHECK: begin
            if (byte_valid) begin
              busy_q <= 1'b0;
              if (8'(sum_q + byte_data) == 8'h00) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= ERROR;
                err_q   <= ERR_CSUM;
                error_q <= 1'b1;
              end
            end
          end
          default: ; // DONE, SKIP, ERROR hold until reset
        endcase
      end
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign skip      = skip_q;
  assign error     = error_q;
  assign err_code  = err_q;

endmodule

// File: tb/tb_uart_boot_loader_ctrl.sv
// Self-checking bench for uart_boot_loader_ctrl: expected RAM writes are
// queued as payload bytes are driven and compared as mem_we pulses appear.
module tb_uart_boot_loader_ctrl;

  localparam int MEM_DEPTH = 4096;
  localparam int ADDR_BITS = $clog2(MEM_DEPTH);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 rx_timeout;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_wdata;
  logic                 busy;
  logic                 done;
  logic                 skip;
  logic                 error;
  logic [1:0]           err_code;

  typedef struct {
    logic [ADDR_BITS-1:0] addr;
    logic [7:0]           data;
  } wr_t;

  wr_t                  exp_q[$];
  int                   n_checks = 0;
  int                   n_pass   = 0;
  int                   wr_total = 0;
  logic [ADDR_BITS-1:0] last_addr = '0;

  uart_boot_loader_ctrl #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .rx_timeout (rx_timeout),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .skip       (skip),
    .error      (error),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Scoreboard: every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we !== 1'b0) begin
      wr_total++;
      last_addr = mem_addr;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic send_payload(input int idx, input logic [7:0] b);
    exp_q.push_back('{addr: ADDR_BITS'(idx), data: b});
    send_byte(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    rx_timeout = 1'b0;
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Full frame with random payload; good=0 corrupts the checksum by one.
  task automatic send_frame(input logic [15:0] len, input bit good);
    logic [7:0] s;
    logic [7:0] b;
    send_byte(8'hA5);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    s = len[7:0] + len[15:8];
    for (int i = 0; i < int'(len); i++) begin
      b = 8'($urandom);
      s = s + b;
      send_payload(i, b);
    end
    send_byte(good ? 8'(-s) : 8'(-s + 8'd1));
  endtask

  task automatic check_flags(input string tag, input logic d, input logic s,
                             input logic e, input logic [1:0] c, input logic bz);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_skip"}, 32'(skip), 32'(s));
    check({tag, "_error"}, 32'(error), 32'(e));
    check({tag, "_code"}, 32'(err_code), 32'(c));
    check({tag, "_busy"}, 32'(busy), 32'(bz));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    rx_timeout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_flags("reset", 0, 0, 0, 2'd0, 0);
    check("reset_we", 32'(mem_we), 32'd0);

    // Worked example with correct checksum 0x97.
    w0 = wr_total;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    check("busy_in_frame", 32'(busy), 32'd1);
    send_payload(0, 8'h11); send_payload(1, 8'h22); send_payload(2, 8'h33);
    send_byte(8'h97);
    check_flags("good3", 1, 0, 0, 2'd0, 0);
    check("good3_writes", 32'(wr_total - w0), 32'd3);
    // Terminal state ignores further bytes and timeouts.
    rx_timeout = 1'b1;
    send_byte(8'hA5); send_byte(8'h01);
    check_flags("good3_hold", 1, 0, 0, 2'd0, 0);
    check("good3_hold_writes", 32'(wr_total - w0), 32'd3);
    do_reset();

    // Same frame with bad checksum 0x85.
    w0 = wr_total;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    send_payload(0, 8'h11); send_payload(1, 8'h22); send_payload(2, 8'h33);
    send_byte(8'h85);
    check_flags("badcsum", 0, 0, 1, 2'd1, 0);
    check("badcsum_writes", 32'(wr_total - w0), 32'd3);
    do_reset();

    // Leading noise then zero-length frame.
    w0 = wr_total;
    send_byte(8'h00); send_byte(8'hFF);
    check("noise_busy", 32'(busy), 32'd0);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check_flags("zerolen", 1, 0, 0, 2'd0, 0);
    check("zerolen_writes", 32'(wr_total - w0), 32'd0);
    do_reset();

    // Length 4097 exceeds the RAM.
    w0 = wr_total;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    check_flags("toolong", 0, 0, 1, 2'd2, 0);
    send_byte(8'h55); send_byte(8'h66);
    check("toolong_writes", 32'(wr_total - w0), 32'd0);
    do_reset();

    // Maximum length 4096 fills the RAM.
    w0 = wr_total;
    send_frame(16'h1000, 1'b1);
    check_flags("maxlen", 1, 0, 0, 2'd0, 0);
    check("maxlen_writes", 32'(wr_total - w0), 32'd4096);
    check("maxlen_last_addr", 32'(last_addr), 32'd4095);
    do_reset();

    // Timeout before any sync byte.
    rx_timeout = 1'b1;
    idle(1);
    check_flags("skip", 0, 1, 0, 2'd0, 0);
    do_reset();

    // Timeout after two payload bytes.
    w0 = wr_total;
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00);
    send_payload(0, 8'hB1); send_payload(1, 8'hB2);
    rx_timeout = 1'b1;
    idle(1);
    check_flags("tmo_mid", 0, 0, 1, 2'd3, 0);
    idle(2);
    check("tmo_mid_writes", 32'(wr_total - w0), 32'd2);
    do_reset();

    // Sync byte and timeout together: byte wins, then timeout aborts.
    rx_timeout = 1'b1;
    send_byte(8'hA5);
    check_flags("sync_tmo", 0, 0, 0, 2'd0, 1);
    idle(1);
    check_flags("sync_tmo_next", 0, 0, 1, 2'd3, 0);
    do_reset();

    // Back-to-back frame cut by reset mid-payload, then a good frame.
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
    send_payload(0, 8'hAA); send_payload(1, 8'hBB);
    do_reset();
    check_flags("midrst", 0, 0, 0, 2'd0, 0);
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_sb_empty", 32'(exp_q.size()), 32'd0);
    w0 = wr_total;
    send_frame(16'd4, 1'b1);
    check_flags("after_rst", 1, 0, 0, 2'd0, 0);
    check("after_rst_writes", 32'(wr_total - w0), 32'd4);

    idle(2);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
